// File: rtl/raster_box_walker_pkg.sv
// Shared types for the rasterizer bounding-box stage: box struct, walker
// state encoding and default screen geometry.
package RasterTypes;

  localparam int COORD_BITS        = 11;
  localparam int SCREEN_WIDTH_DEF  = 640;
  localparam int SCREEN_HEIGHT_DEF = 480;

  typedef struct packed {
    logic [COORD_BITS-1:0] minX;
    logic [COORD_BITS-1:0] minY;
    logic [COORD_BITS-1:0] maxX;
    logic [COORD_BITS-1:0] maxY;
  } TriangleData;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BOX  = 2'd1,
    WALK = 2'd2
  } walker_state_t;

endpackage

// File: rtl/raster_box_walker_bbox_clip.sv
// Combinational bounding box of three vertices, with max edges clipped to the
// screen and an off-screen flag taken from the unclipped min corner.
module bbox_clip
  import RasterTypes::*;
(
  input  logic [1:0][COORD_BITS-1:0] p1,
  input  logic [1:0][COORD_BITS-1:0] p2,
  input  logic [1:0][COORD_BITS-1:0] p3,
  input  logic [COORD_BITS-1:0]      limit_x,
  input  logic [COORD_BITS-1:0]      limit_y,
  output TriangleData                box,
  output logic                       offscreen
);

  logic [COORD_BITS-1:0] min_x, max_x, min_y, max_y;

  always_comb begin
    min_x = p1[0];
    max_x = p1[0];
    min_y = p1[1];
    max_y = p1[1];
    if (p2[0] < min_x) min_x = p2[0];
    if (p3[0] < min_x) min_x = p3[0];
    if (p2[0] > max_x) max_x = p2[0];
    if (p3[0] > max_x) max_x = p3[0];
    if (p2[1] < min_y) min_y = p2[1];
    if (p3[1] < min_y) min_y = p3[1];
    if (p2[1] > max_y) max_y = p2[1];
    if (p3[1] > max_y) max_y = p3[1];

    box.minX  = min_x;
    box.minY  = min_y;
    box.maxX  = (max_x > limit_x) ? limit_x : max_x;
    box.maxY  = (max_y > limit_y) ? limit_y : max_y;
    // A min corner past the screen edge means nothing of the box is visible.
    offscreen = (min_x > limit_x) || (min_y > limit_y);
  end

endmodule

// File: rtl/raster_box_walker.sv
// Accepts one triangle, computes its clipped bounding box and walks every
// pixel of it in row-major order over a valid/ready handshake.
module raster_box_walker
  import RasterTypes::*;
#(
  parameter int COORD_W       = COORD_BITS,
  parameter int SCREEN_WIDTH  = SCREEN_WIDTH_DEF,
  parameter int SCREEN_HEIGHT = SCREEN_HEIGHT_DEF,
  parameter int COUNT_W       = 16
) (
  input  logic                     aClock,
  input  logic                     aReset,
  input  logic                     aTriValid,
  output logic                     anOutTriReady,
  input  logic [1:0][COORD_W-1:0]  aPoint1,
  input  logic [1:0][COORD_W-1:0]  aPoint2,
  input  logic [1:0][COORD_W-1:0]  aPoint3,
  output logic                     anOutPixelValid,
  input  logic                     aPixelReady,
  output logic [COORD_W-1:0]       anOutPixelX,
  output logic [COORD_W-1:0]       anOutPixelY,
  output logic                     anOutLastPixel,
  output logic                     anOutCulled,
  output logic                     anOutBusy,
  output logic [COUNT_W-1:0]       anOutTriCount
);

  localparam logic [COORD_W-1:0] LIMIT_X = COORD_W'(SCREEN_WIDTH - 1);
  localparam logic [COORD_W-1:0] LIMIT_Y = COORD_W'(SCREEN_HEIGHT - 1);

  // Handshakes: a transfer happens on any rising edge where valid and ready
  // are both high; valid never waits on ready, and payload holds while stalled.
  walker_state_t            state;
  logic [1:0][COORD_W-1:0]  v1, v2, v3;
  TriangleData              box_d, box_q;
  logic                     offscreen;
  logic [COORD_W-1:0]       cur_x, cur_y;
  logic                     culled;
  logic [COUNT_W-1:0]       count;
  logic                     is_last;

  bbox_clip u_bbox_clip (
    .p1        (v1),
    .p2        (v2),
    .p3        (v3),
    .limit_x   (LIMIT_X),
    .limit_y   (LIMIT_Y),
    .box       (box_d),
    .offscreen (offscreen)
  );

  assign is_last         = (state == WALK) && (cur_x == box_q.maxX) && (cur_y == box_q.maxY);
  assign anOutTriReady   = (state == IDLE) && !aReset;
  assign anOutBusy       = (state != IDLE);
  assign anOutPixelValid = (state == WALK);
  assign anOutPixelX     = cur_x;
  assign anOutPixelY     = cur_y;
  assign anOutLastPixel  = is_last;
  assign anOutCulled     = culled;
  assign anOutTriCount   = count;

  always_ff @(posedge aClock) begin
    if (aReset) begin
      state  <= IDLE;
      count  <= '0;
      cur_x  <= '0;
      cur_y  <= '0;
      culled <= 1'b0;
    end else begin
      culled <= 1'b0;
      case (state)
        IDLE: begin
          if (aTriValid) begin
            v1    <= aPoint1;
            v2    <= aPoint2;
            v3    <= aPoint3;
            state <= BOX;
          end
        end
        BOX: begin
          if (offscreen) begin
            culled <= 1'b1;
            count  <= count + COUNT_W'(1);
            state  <= IDLE;
          end else begin
            box_q <= box_d;
            cur_x <= box_d.minX;
            cur_y <= box_d.minY;
            state <= WALK;
          end
        end
        WALK: begin
          if (aPixelReady) begin
            if (is_last) begin
              count <= count + COUNT_W'(1);
              state <= IDLE;
            end else if (cur_x == box_q.maxX) begin
              cur_x <= box_q.minX;
              cur_y <= cur_y + COORD_W'(1);
            end else begin
              cur_x <= cur_x + COORD_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_raster_box_walker.sv
// Bench for raster_box_walker: a pixel-list model of each triangle feeds an
// expected queue that is checked against the DUT every cycle.
module tb_raster_box_walker;

  localparam int CW = 11;
  localparam int SW = 640;
  localparam int SH = 480;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              tri_valid = 1'b0;
  logic              tri_ready;
  logic [1:0][CW-1:0] pt1 = '0, pt2 = '0, pt3 = '0;
  logic              pix_valid;
  logic              pix_ready = 1'b1;
  logic [CW-1:0]     pix_x, pix_y;
  logic              pix_last, culled, busy;
  logic [15:0]       tri_count;

  int errors = 0;
  int checks = 0;

  // {last, x, y} per expected pixel, in walk order
  logic [2*CW:0] exp_q[$];
  int  exp_cnt     = 0;
  bit  box_pending = 0;
  bit  exp_cull    = 0;
  bit  cull_next   = 0;
  int  popped      = 0;
  bit  stall_mode  = 0;

  always #5 clk = ~clk;

  raster_box_walker dut (
    .aClock          (clk),
    .aReset          (rst),
    .aTriValid       (tri_valid),
    .anOutTriReady   (tri_ready),
    .aPoint1         (pt1),
    .aPoint2         (pt2),
    .aPoint3         (pt3),
    .anOutPixelValid (pix_valid),
    .aPixelReady     (pix_ready),
    .anOutPixelX     (pix_x),
    .anOutPixelY     (pix_y),
    .anOutLastPixel  (pix_last),
    .anOutCulled     (culled),
    .anOutBusy       (busy),
    .anOutTriCount   (tri_count)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: list every pixel of the clipped box, or flag a cull.
  task automatic model_load(input int x1, y1, x2, y2, x3, y3);
    int mnx, mxx, mny, mxy;
    logic [CW-1:0] xv, yv;
    mnx = x1; if (x2 < mnx) mnx = x2; if (x3 < mnx) mnx = x3;
    mxx = x1; if (x2 > mxx) mxx = x2; if (x3 > mxx) mxx = x3;
    mny = y1; if (y2 < mny) mny = y2; if (y3 < mny) mny = y3;
    mxy = y1; if (y2 > mxy) mxy = y2; if (y3 > mxy) mxy = y3;
    exp_q.delete();
    box_pending = 1;
    exp_cull = (mnx > SW - 1) || (mny > SH - 1);
    if (!exp_cull) begin
      if (mxx > SW - 1) mxx = SW - 1;
      if (mxy > SH - 1) mxy = SH - 1;
      for (int y = mny; y <= mxy; y++)
        for (int x = mnx; x <= mxx; x++) begin
          xv = CW'(x);
          yv = CW'(y);
          exp_q.push_back({(x == mxx && y == mxy), xv, yv});
        end
    end
  endtask

  // Per-cycle compare against the model; pops on observed handshakes.
  always @(negedge clk) begin
    bit exp_valid, exp_busy, exp_culled;
    logic [2*CW:0] f;
    if (rst) begin
      exp_q.delete();
      exp_cnt = 0;
      box_pending = 0;
      cull_next = 0;
    end else begin
      exp_culled = cull_next;
      cull_next = 0;
      if (box_pending) begin
        exp_valid = 0;
        exp_busy  = 1;
      end else begin
        exp_valid = (exp_q.size() > 0);
        exp_busy  = exp_valid;
      end
      chk("pix_valid", int'(pix_valid), int'(exp_valid));
      chk("busy", int'(busy), int'(exp_busy));
      chk("tri_ready", int'(tri_ready), int'(!exp_busy));
      chk("culled", int'(culled), int'(exp_culled));
      chk("tri_count", int'(tri_count), exp_cnt);
      if (exp_valid) begin
        f = exp_q[0];
        chk("pix_x", int'(pix_x), int'(f[2*CW-1:CW]));
        chk("pix_y", int'(pix_y), int'(f[CW-1:0]));
        chk("pix_last", int'(pix_last), int'(f[2*CW]));
        if (pix_valid && pix_ready) begin
          void'(exp_q.pop_front());
          popped++;
          if (f[2*CW]) exp_cnt = (exp_cnt + 1) % 65536;
        end
      end else begin
        chk("pix_last_idle", int'(pix_last), 0);
      end
      if (box_pending) begin
        box_pending = 0;
        if (exp_cull) begin
          cull_next = 1;
          exp_cnt = (exp_cnt + 1) % 65536;
        end
      end
    end
  end

  // Ready driver: held high, or cycling 1,0,0,1 when stalling.
  initial begin
    int k;
    logic [3:0] pat;
    pat = 4'b1001;
    k = 0;
    forever begin
      @(posedge clk);
      #1;
      pix_ready = stall_mode ? pat[3 - (k % 4)] : 1'b1;
      k++;
    end
  end

  task automatic send_tri(input int x1, y1, x2, y2, x3, y3);
    bit ok;
    ok = 0;
    @(posedge clk);
    #1;
    pt1 = {CW'(y1), CW'(x1)};
    pt2 = {CW'(y2), CW'(x2)};
    pt3 = {CW'(y3), CW'(x3)};
    tri_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tri_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      chk("accept_timeout", 0, 1);
      tri_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      tri_valid = 1'b0;
      model_load(x1, y1, x2, y2, x3, y3);
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && !box_pending && !cull_next && !busy) begin ok = 1; break; end
    end
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  task automatic wait_popped(input int n);
    bit ok;
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      if (popped >= n) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) chk("pop_timeout", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    logic [2*CW:0] e;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(pix_valid), 0);
    chk("rst_ready", int'(tri_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_culled", int'(culled), 0);
    chk("rst_last", int'(pix_last), 0);
    chk("rst_x", int'(pix_x), 0);
    chk("rst_y", int'(pix_y), 0);
    chk("rst_count", int'(tri_count), 0);
    rst = 1'b0;

    // small box, ready held high
    send_tri(2, 3, 4, 3, 3, 4);
    chk("model_len_t1", exp_q.size(), 6);
    e = exp_q[0];
    chk("model_first_t1", int'(e), int'({1'b0, 11'd2, 11'd3}));
    e = exp_q[5];
    chk("model_last_t1", int'(e), int'({1'b1, 11'd4, 11'd4}));
    wait_idle();
    chk("count_t1", int'(tri_count), 1);

    // same triangle under backpressure
    stall_mode = 1;
    send_tri(2, 3, 4, 3, 3, 4);
    wait_idle();
    stall_mode = 0;
    chk("count_t2", int'(tri_count), 2);

    // clipped at the bottom-right corner
    send_tri(630, 470, 700, 470, 630, 500);
    chk("model_len_t3", exp_q.size(), 100);
    e = exp_q[99];
    chk("model_last_t3", int'(e), int'({1'b1, 11'd639, 11'd479}));
    wait_idle();
    chk("count_t3", int'(tri_count), 3);

    // fully off-screen: culled
    send_tri(700, 10, 800, 10, 750, 20);
    chk("model_cull_t4", int'(exp_cull), 1);
    wait_idle();
    chk("count_t4", int'(tri_count), 4);

    // degenerate single pixel
    send_tri(5, 5, 5, 5, 5, 5);
    chk("model_len_t5", exp_q.size(), 1);
    wait_idle();
    chk("count_t5", int'(tri_count), 5);

    // vertex exactly on the right edge stays on-screen
    send_tri(639, 0, 639, 1, 639, 0);
    chk("model_len_edge", exp_q.size(), 2);
    wait_idle();
    chk("count_edge", int'(tri_count), 6);

    // reset in the middle of a walk
    popped = 0;
    send_tri(630, 470, 700, 470, 630, 500);
    wait_popped(3);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_valid", int'(pix_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_last", int'(pix_last), 0);
    chk("midrst_count", int'(tri_count), 0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("ready_after_rst", int'(tri_ready), 1);

    send_tri(2, 3, 4, 3, 3, 4);
    wait_idle();
    chk("count_after_rst", int'(tri_count), 1);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
